// File: rtl/fb_arbiter_pkg.sv
// Shared types and defaults for the frame-buffer arbiter.
package fb_arbiter_pkg;

  localparam int FB_ADDR_W       = 17;
  localparam int FB_DATA_W       = 12;
  localparam int FB_STARVE_LIMIT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Travels with each issued read so the response can be steered two cycles later.
  typedef struct packed {
    logic cpu;
    logic disp;
    logic last;
  } rtag_t;

endpackage

// File: rtl/fb_arb_rtag.sv
// Two-deep read-tag pipeline matching the one-cycle RAM latency plus the registered issue stage.
module fb_arb_rtag
  import fb_arbiter_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  rtag_t tag_in,
  output logic  cpu_rvalid,
  output logic  disp_rvalid,
  output logic  disp_done
);

  rtag_t stage1;
  rtag_t stage2;

  always_ff @(posedge clock) begin
    if (reset) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1 <= tag_in;
      stage2 <= stage1;
    end
  end

  assign cpu_rvalid  = stage2.cpu;
  assign disp_rvalid = stage2.disp;
  assign disp_done   = stage2.disp && stage2.last;

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: single-port RAM shared between CPU accesses and display bursts,
// with starvation counters bounding how long either side can be locked out.
//
// state | meaning
// IDLE  | no burst open; CPU wins unless display is urgent or starved
// BURST | display beats issuing; CPU may steal single cycles
module fb_arbiter
  import fb_arbiter_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int STARVE_LIMIT = FB_STARVE_LIMIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic [3:0]        disp_len,
  input  logic              disp_urgent,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  output logic              disp_done,
  output logic              fb_en,
  output logic              fb_wen,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_wdata,
  input  logic [DATA_W-1:0] fb_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_t        state;
  logic [ADDR_W-1:0] base;
  logic [4:0]        beats;
  logic [4:0]        idx;
  logic [CW-1:0]     cpu_wait;
  logic [CW-1:0]     disp_wait;

  logic              disp_fav;
  logic              cpu_steal;
  logic              cpu_win;
  logic              disp_win;
  logic              disp_issue;
  logic              disp_lose;
  logic              issue_last;
  logic [ADDR_W-1:0] beat_addr;
  rtag_t             tag_in;

  // Decisions are forced idle during reset so nothing issues or grants in that cycle.
  always_comb begin
    disp_fav   = disp_req && (disp_urgent || disp_wait == LIMIT);
    cpu_steal  = cpu_req && (!disp_urgent || cpu_wait == LIMIT) && (disp_wait < LIMIT);
    cpu_win    = 1'b0;
    disp_win   = 1'b0;
    disp_issue = 1'b0;
    disp_lose  = 1'b0;
    issue_last = 1'b0;
    beat_addr  = base + ADDR_W'(idx);
    if (!reset) begin
      if (state == IDLE) begin
        cpu_win    = cpu_req && !disp_fav;
        disp_win   = disp_req && !cpu_win;
        disp_issue = disp_win;
        disp_lose  = disp_req && !disp_win;
        issue_last = disp_win && (disp_len == 4'd0);
        beat_addr  = disp_addr;
      end else begin
        cpu_win    = cpu_steal;
        disp_issue = !cpu_steal;
        disp_lose  = cpu_steal;
        issue_last = !cpu_steal && (idx == beats - 5'd1);
      end
    end
  end

  assign cpu_stall  = cpu_req && !cpu_win;
  assign disp_gnt   = disp_win;
  assign cpu_rdata  = fb_rdata;
  assign disp_rdata = fb_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      base      <= '0;
      beats     <= '0;
      idx       <= '0;
      cpu_wait  <= '0;
      disp_wait <= '0;
      fb_en     <= 1'b0;
      fb_wen    <= 1'b0;
      fb_addr   <= '0;
      fb_wdata  <= '0;
    end else begin
      fb_en  <= cpu_win || disp_issue;
      fb_wen <= cpu_win && cpu_wen;
      if (cpu_win) begin
        fb_addr  <= cpu_addr;
        fb_wdata <= cpu_wdata;
      end else if (disp_issue) begin
        fb_addr <= beat_addr;
      end

      if (cpu_stall) begin
        if (cpu_wait != LIMIT) cpu_wait <= cpu_wait + 1'b1;
      end else begin
        cpu_wait <= '0;
      end

      if (disp_issue) begin
        disp_wait <= '0;
      end else if (disp_lose && disp_wait != LIMIT) begin
        disp_wait <= disp_wait + 1'b1;
      end

      if (state == IDLE) begin
        if (disp_win) begin
          base  <= disp_addr;
          beats <= 5'(disp_len) + 5'd1;
          idx   <= 5'd1;
          state <= (disp_len == 4'd0) ? IDLE : BURST;
        end
      end else if (disp_issue) begin
        idx <= idx + 5'd1;
        if (issue_last) state <= IDLE;
      end
    end
  end

  assign tag_in = '{cpu: cpu_win && !cpu_wen, disp: disp_issue, last: issue_last};

  fb_arb_rtag u_rtag (
    .clock       (clock),
    .reset       (reset),
    .tag_in      (tag_in),
    .cpu_rvalid  (cpu_rvalid),
    .disp_rvalid (disp_rvalid),
    .disp_done   (disp_done)
  );

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter: expected RAM accesses and read returns are queued with
// the cycle they are due, and a negedge monitor checks the DUT against them every cycle.
module tb_fb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wen;
  logic [16:0] cpu_addr;
  logic [11:0] cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [11:0] cpu_rdata;
  logic        disp_req, disp_urgent;
  logic [16:0] disp_addr;
  logic [3:0]  disp_len;
  logic        disp_gnt, disp_rvalid, disp_done;
  logic [11:0] disp_rdata;
  logic        fb_en, fb_wen;
  logic [16:0] fb_addr;
  logic [11:0] fb_wdata;
  logic [11:0] fb_rdata = '0;

  fb_arbiter dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_len(disp_len), .disp_urgent(disp_urgent),
    .disp_gnt(disp_gnt), .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid), .disp_done(disp_done),
    .fb_en(fb_en), .fb_wen(fb_wen), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_rdata(fb_rdata)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [11:0] pat(input logic [16:0] a);
    return a[11:0] ^ {7'd0, a[16:12]} ^ 12'h5A5;
  endfunction

  // RAM model: one-cycle read latency, preloaded with an address-derived pattern.
  logic [11:0] mem [0:131071];
  initial for (int i = 0; i < 131072; i++) mem[i] = pat(17'(i));
  always @(posedge clock) begin
    if (fb_en) begin
      if (fb_wen) mem[fb_addr] = fb_wdata;
      else        fb_rdata = mem[fb_addr];
    end
  end

  typedef struct { int due; logic wen; logic [16:0] addr; logic [11:0] wdata; } fb_exp_t;
  typedef struct { int due; logic [11:0] data; logic last; } rd_exp_t;
  fb_exp_t fb_q[$];
  rd_exp_t cpu_q[$];
  rd_exp_t disp_q[$];

  task automatic push_fb(input int due, input logic wen, input logic [16:0] addr, input logic [11:0] wdata);
    fb_q.push_back('{due: due, wen: wen, addr: addr, wdata: wdata});
  endtask

  task automatic push_cpu_rd(input int due, input logic [11:0] data);
    cpu_q.push_back('{due: due, data: data, last: 1'b0});
  endtask

  task automatic push_disp_rd(input int due, input logic [11:0] data, input logic last);
    disp_q.push_back('{due: due, data: data, last: last});
  endtask

  always @(negedge clock) begin : monitor
    fb_exp_t fe;
    rd_exp_t re;
    logic exp_en, exp_c, exp_d, exp_last;
    if (mon_on) begin
      exp_en = fb_q.size() > 0 && fb_q[0].due == cyc;
      chk("fb_en", 32'(fb_en), 32'(exp_en));
      if (exp_en) begin
        fe = fb_q.pop_front();
        if (fb_en) begin
          chk("fb_addr", 32'(fb_addr), 32'(fe.addr));
          chk("fb_wen", 32'(fb_wen), 32'(fe.wen));
          if (fe.wen) chk("fb_wdata", 32'(fb_wdata), 32'(fe.wdata));
        end
      end
      exp_c = cpu_q.size() > 0 && cpu_q[0].due == cyc;
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_c));
      if (exp_c) begin
        re = cpu_q.pop_front();
        if (cpu_rvalid) chk("cpu_rdata", 32'(cpu_rdata), 32'(re.data));
      end
      exp_d    = disp_q.size() > 0 && disp_q[0].due == cyc;
      exp_last = 1'b0;
      chk("disp_rvalid", 32'(disp_rvalid), 32'(exp_d));
      if (exp_d) begin
        re = disp_q.pop_front();
        exp_last = re.last;
        if (disp_rvalid) chk("disp_rdata", 32'(disp_rdata), 32'(re.data));
      end
      chk("disp_done", 32'(disp_done), 32'(exp_last));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_wen = 0; cpu_addr = '0; cpu_wdata = '0;
    disp_req = 0; disp_urgent = 0; disp_addr = '0; disp_len = '0;
  endtask

  initial begin
    int n;
    logic [16:0] a;
    logic beat, cwin;
    int b;

    // Reset with an urgent display request pending: nothing may be granted.
    reset = 1'b1;
    idle_inputs();
    disp_req = 1; disp_urgent = 1;
    tick();
    mon_on = 1'b1;
    settle();
    chk("rst_gnt", 32'(disp_gnt), 32'(0));
    chk("rst_fb_addr", 32'(fb_addr), 32'(0));
    chk("rst_fb_wdata", 32'(fb_wdata), 32'(0));
    chk("rst_fb_wen", 32'(fb_wen), 32'(0));
    tick();
    reset = 1'b0;
    idle_inputs();
    repeat (2) tick();

    // CPU-only read.
    n = cyc;
    cpu_req = 1; cpu_wen = 0; cpu_addr = 17'h00100;
    push_fb(n + 1, 0, 17'h00100, '0);
    push_cpu_rd(n + 2, pat(17'h00100));
    settle();
    chk("cpu_rd_stall", 32'(cpu_stall), 32'(0));
    tick();
    cpu_req = 0;
    repeat (3) tick();

    // CPU write then read-back of the same word.
    n = cyc;
    cpu_req = 1; cpu_wen = 1; cpu_addr = 17'h00200; cpu_wdata = 12'h123;
    push_fb(n + 1, 1, 17'h00200, 12'h123);
    tick();
    cpu_wen = 0;
    push_fb(n + 2, 0, 17'h00200, '0);
    push_cpu_rd(n + 3, 12'h123);
    tick();
    cpu_req = 0;
    repeat (3) tick();

    // 4-beat burst wrapping the top of the address space.
    n = cyc;
    disp_req = 1; disp_urgent = 0; disp_len = 4'd3; disp_addr = 17'h1FFFE;
    for (int i = 0; i < 4; i++) begin
      a = 17'h1FFFE + 17'(i);
      push_fb(n + 1 + i, 0, a, '0);
      push_disp_rd(n + 2 + i, pat(a), i == 3);
    end
    settle();
    chk("b4_gnt", 32'(disp_gnt), 32'(1));
    tick();
    disp_req = 0;
    settle();
    chk("b4_gnt_pulse", 32'(disp_gnt), 32'(0));
    repeat (6) tick();

    // Single-beat burst stays in IDLE so a new request is granted the very next cycle.
    n = cyc;
    disp_req = 1; disp_len = 4'd0; disp_addr = 17'h00040;
    push_fb(n + 1, 0, 17'h00040, '0);
    push_disp_rd(n + 2, pat(17'h00040), 1);
    settle();
    chk("b1_gnt", 32'(disp_gnt), 32'(1));
    tick();
    disp_len = 4'd1; disp_addr = 17'h00050;
    push_fb(n + 2, 0, 17'h00050, '0);
    push_fb(n + 3, 0, 17'h00051, '0);
    push_disp_rd(n + 3, pat(17'h00050), 0);
    push_disp_rd(n + 4, pat(17'h00051), 1);
    settle();
    chk("b1_regrant", 32'(disp_gnt), 32'(1));
    tick();
    disp_req = 0;
    repeat (5) tick();

    // Simultaneous CPU write and non-urgent display request.
    n = cyc;
    cpu_req = 1; cpu_wen = 1; cpu_addr = 17'h00010; cpu_wdata = 12'hABC;
    disp_req = 1; disp_urgent = 0; disp_len = 4'd1; disp_addr = 17'h00300;
    push_fb(n + 1, 1, 17'h00010, 12'hABC);
    settle();
    chk("sim_cpu_stall", 32'(cpu_stall), 32'(0));
    chk("sim_gnt0", 32'(disp_gnt), 32'(0));
    tick();
    cpu_req = 0;
    push_fb(n + 2, 0, 17'h00300, '0);
    push_fb(n + 3, 0, 17'h00301, '0);
    push_disp_rd(n + 3, pat(17'h00300), 0);
    push_disp_rd(n + 4, pat(17'h00301), 1);
    settle();
    chk("sim_gnt1", 32'(disp_gnt), 32'(1));
    tick();
    disp_req = 0;
    repeat (3) tick();
    n = cyc;
    cpu_req = 1; cpu_wen = 0; cpu_addr = 17'h00010;
    push_fb(n + 1, 0, 17'h00010, '0);
    push_cpu_rd(n + 2, 12'hABC);
    tick();
    cpu_req = 0;
    repeat (3) tick();

    // Non-urgent 8-beat burst against continuous CPU reads: 4 CPU wins, 1 beat, repeat.
    n = cyc;
    for (int t = 0; t < 42; t++) begin
      if (t > 0) tick();
      cpu_req = 1; cpu_wen = 0; cpu_addr = 17'h00500 + 17'(t);
      disp_req = (t <= 4); disp_urgent = 0; disp_len = 4'd7; disp_addr = 17'h01000;
      beat = (t >= 4) && (t <= 39) && ((t - 4) % 5 == 0);
      b = (t - 4) / 5;
      if (beat) begin
        a = 17'h01000 + 17'(b);
        push_fb(n + t + 1, 0, a, '0);
        push_disp_rd(n + t + 2, pat(a), b == 7);
      end else begin
        push_fb(n + t + 1, 0, cpu_addr, '0);
        push_cpu_rd(n + t + 2, pat(cpu_addr));
      end
      settle();
      chk("nu_stall", 32'(cpu_stall), 32'(beat));
      chk("nu_gnt", 32'(disp_gnt), 32'(t == 4));
    end
    tick();
    idle_inputs();
    repeat (4) tick();

    // Urgent 8-beat burst against continuous CPU writes: 4 stalls, 1 CPU win, repeat.
    n = cyc;
    for (int t = 0; t < 11; t++) begin
      if (t > 0) tick();
      cpu_req = 1; cpu_wen = 1; cpu_addr = 17'h00600 + 17'(t); cpu_wdata = 12'(t + 1);
      disp_req = (t == 0); disp_urgent = 1; disp_len = 4'd7; disp_addr = 17'h02000;
      cwin = (t == 4) || (t >= 9);
      b = (t < 4) ? t : t - 1;
      if (cwin) begin
        push_fb(n + t + 1, 1, cpu_addr, cpu_wdata);
      end else begin
        a = 17'h02000 + 17'(b);
        push_fb(n + t + 1, 0, a, '0);
        push_disp_rd(n + t + 2, pat(a), b == 7);
      end
      settle();
      chk("ur_stall", 32'(cpu_stall), 32'(!cwin));
      chk("ur_gnt", 32'(disp_gnt), 32'(t == 0));
    end
    tick();
    idle_inputs();
    repeat (4) tick();

    // Reset in the cycle beat 3 of a 16-beat burst would issue.
    n = cyc;
    disp_req = 1; disp_urgent = 0; disp_len = 4'd15; disp_addr = 17'h03000;
    for (int i = 0; i < 3; i++) push_fb(n + 1 + i, 0, 17'h03000 + 17'(i), '0);
    for (int i = 0; i < 2; i++) push_disp_rd(n + 2 + i, pat(17'h03000 + 17'(i)), 0);
    settle();
    chk("rb_gnt", 32'(disp_gnt), 32'(1));
    tick();
    disp_req = 0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("rb_fb_en", 32'(fb_en), 32'(0));
    chk("rb_fb_addr", 32'(fb_addr), 32'(0));
    chk("rb_rvalid1", 32'(disp_rvalid), 32'(0));
    tick();
    settle();
    chk("rb_rvalid2", 32'(disp_rvalid), 32'(0));
    chk("rb_done2", 32'(disp_done), 32'(0));
    repeat (4) begin
      tick();
      settle();
      chk("rb_idle_fb_en", 32'(fb_en), 32'(0));
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
